dd_input_cond: RTL

//  Input-side conditioner for the DigDug core: cleans the raw board buttons and keys and builds the INP0/INP1 bytes.

---
 rtl/dd_input_cond.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/dd_input_cond.sv
// DigDug input conditioner: sync, debounce, coin stretch,
// reset combo and INP0/INP1 byte assembly.
module dd_input_cond #(
  parameter int TICK_DIV    = 48000,
  parameter int DEB_TICKS   = 10,
  parameter int COIN_TICKS  = 100,
  parameter int RST_TICKS   = 2000,
  parameter int IN_ACT_LOW  = 1,
  parameter int OUT_ACT_LOW = 1
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic       SW_LEFT,
  input  logic       SW_RIGHT,
  input  logic       SW_UP,
  input  logic       SW_DOWN,
  input  logic       SW_FIRE,
  input  logic [3:0] key_in,
  output logic [7:0] INP0,
  output logic [7:0] INP1,
  output logic       resetKey
);

  localparam int NIN = 9;
  localparam int PW  = $clog2(TICK_DIV) + 1;
  localparam int DW  = $clog2(DEB_TICKS) + 1;
  localparam int CW  = $clog2(COIN_TICKS) + 1;
  localparam int RW  = $clog2(RST_TICKS) + 1;

  localparam logic [NIN-1:0] RAW_REL =
    (IN_ACT_LOW != 0) ? '1 : '0;
  localparam logic [7:0] OUT_INV =
    (OUT_ACT_LOW != 0) ? 8'hFF : 8'h00;

  localparam int I_LEFT   = 0;
  localparam int I_RIGHT  = 1;
  localparam int I_UP     = 2;
  localparam int I_DOWN   = 3;
  localparam int I_FIRE   = 4;
  localparam int I_COIN1  = 5;
  localparam int I_START1 = 6;
  localparam int I_START2 = 7;
  localparam int I_COIN2  = 8;

  typedef enum logic {
    C_IDLE,
    C_PULSE
  } coin_st_t;

  logic [NIN-1:0] raw;
  logic [NIN-1:0] s1;
  logic [NIN-1:0] s2;
  logic [NIN-1:0] smp;

  assign raw = {
    key_in[3],
    key_in[2],
    key_in[1],
    key_in[0],
    SW_FIRE,
    SW_DOWN,
    SW_UP,
    SW_RIGHT,
    SW_LEFT
  };

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      s1 <= RAW_REL;
      s2 <= RAW_REL;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  assign smp = s2 ^ RAW_REL;

  logic [PW-1:0] pcnt;
  logic          tick;

  assign tick = (pcnt == PW'(TICK_DIV - 1));

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  logic [NIN-1:0] deb;
  logic [DW-1:0]  dcnt [NIN];

  // Accept on the tick that makes the count reach DEB_TICKS.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      deb <= '0;
      for (int i = 0; i < NIN; i++) begin
        dcnt[i] <= '0;
      end
    end else if (tick) begin
      for (int i = 0; i < NIN; i++) begin
        if (smp[i] != deb[i]) begin
          if (dcnt[i] == DW'(DEB_TICKS - 1)) begin
            deb[i]  <= smp[i];
            dcnt[i] <= '0;
          end else begin
            dcnt[i] <= dcnt[i] + DW'(1);
          end
        end else begin
          dcnt[i] <= '0;
        end
      end
    end
  end

  logic [1:0]    coin_deb;
  logic [1:0]    coin_prev;
  logic [1:0]    coin_rise;
  logic [1:0]    coin_on;
  coin_st_t      cst    [2];
  coin_st_t      cst_nx [2];
  logic [CW-1:0] ctmr    [2];
  logic [CW-1:0] ctmr_nx [2];

  assign coin_deb  = {deb[I_COIN2], deb[I_COIN1]};
  assign coin_rise = coin_deb & ~coin_prev;

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      coin_prev <= '0;
      for (int c = 0; c < 2; c++) begin
        cst[c]  <= C_IDLE;
        ctmr[c] <= '0;
      end
    end else begin
      coin_prev <= coin_deb;
      for (int c = 0; c < 2; c++) begin
        cst[c]  <= cst_nx[c];
        ctmr[c] <= ctmr_nx[c];
      end
    end
  end

  // Edges seen while pulsing are dropped, so holds never re-trigger.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      cst_nx[c]  = cst[c];
      ctmr_nx[c] = ctmr[c];
      coin_on[c] = 1'b0;
      unique case (cst[c])
        C_IDLE: begin
          if (coin_rise[c]) begin
            cst_nx[c]  = C_PULSE;
            ctmr_nx[c] = CW'(COIN_TICKS);
          end
        end
        C_PULSE: begin
          coin_on[c] = 1'b1;
          if (tick) begin
            if (ctmr[c] <= CW'(1)) begin
              cst_nx[c]  = C_IDLE;
              ctmr_nx[c] = '0;
            end else begin
              ctmr_nx[c] = ctmr[c] - CW'(1);
            end
          end
        end
        default: begin
          cst_nx[c]  = C_IDLE;
          ctmr_nx[c] = '0;
        end
      endcase
    end
  end

  logic          both;
  logic          sat;
  logic [RW-1:0] rcnt;

  assign both = deb[I_START1] & deb[I_START2];
  assign sat  = (rcnt == RW'(RST_TICKS));

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      rcnt     <= '0;
      resetKey <= 1'b0;
    end else begin
      if (!both) begin
        rcnt <= '0;
      end else if (tick && !sat) begin
        rcnt <= rcnt + RW'(1);
      end
      resetKey <= both & sat;
    end
  end

  logic [7:0] inp0_p;
  logic [7:0] inp1_p;

  assign inp0_p = {
    1'b0,
    1'b0,
    coin_on[1],
    coin_on[0],
    deb[I_START2],
    deb[I_START1],
    deb[I_FIRE],
    deb[I_FIRE]
  };

  assign inp1_p = {
    deb[I_LEFT],
    deb[I_DOWN],
    deb[I_RIGHT],
    deb[I_UP],
    deb[I_LEFT],
    deb[I_DOWN],
    deb[I_RIGHT],
    deb[I_UP]
  };

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      INP0 <= OUT_INV;
      INP1 <= OUT_INV;
    end else begin
      INP0 <= inp0_p ^ OUT_INV;
      INP1 <= inp1_p ^ OUT_INV;
    end
  end

endmodule
